// File: rtl/weight_load_control_unit_pkg.sv
// Shared constants and state type for the weight loader.
package weight_load_control_unit_pkg;

  localparam int MUL_SIZE   = 32;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int ROW_W      = 5;
  localparam int TILE_W     = 3;
  localparam int ROW_DATA_W = MUL_SIZE * DATA_W;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MUL_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_BANK,
    ST_DRAIN
  } wl_state_e;

endpackage

// File: rtl/weight_load_control_unit_row_pipe.sv
// One-stage alignment of read strobe, row index and bank with the returned
// memory row. Read data is sampled on the clock edge that closes the strobe
// cycle, so the registered row lines up with the delayed valid.
module weight_load_control_unit_row_pipe
  import weight_load_control_unit_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic [ROW_W-1:0]      idx_i,
  input  logic                  bank_i,
  input  logic [ROW_DATA_W-1:0] rd_data_i,
  output logic [ROW_DATA_W-1:0] row_o,
  output logic                  valid_o,
  output logic [ROW_W-1:0]      idx_o,
  output logic                  bank_o,
  output logic                  last_wr_o
);

  logic                  valid_q;
  logic [ROW_W-1:0]      idx_q;
  logic                  bank_q;
  logic [ROW_DATA_W-1:0] row_q;

  // Delay strobe/index/bank by one cycle and capture the row being read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      bank_q  <= 1'b0;
      row_q   <= '0;
    end else begin
      valid_q <= rd_en_i;
      idx_q   <= idx_i;
      bank_q  <= bank_i;
      if (rd_en_i) row_q <= rd_data_i;
    end
  end

  assign row_o     = row_q;
  assign valid_o   = valid_q;
  assign idx_o     = idx_q;
  assign bank_o    = bank_q;
  assign last_wr_o = valid_q && (idx_q == ROW_LAST);

endmodule

// File: rtl/weight_load_control_unit.sv
// Weight tile loader: reads tiles row by row from weight memory into the free
// half of the MAC array's double-buffered weight registers, tracking how many
// banks are reserved (being loaded or loaded) and how many are fully loaded.
module weight_load_control_unit
  import weight_load_control_unit_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            MAC_op_i,
  input  logic [7:0]            U_dim_i,
  input  logic                  next_weight_tile_i,
  output logic                  weight_rd_en_o,
  output logic [ADDR_W-1:0]     weight_rd_addr_o,
  input  logic [ROW_DATA_W-1:0] weight_rd_data_i,
  output logic [ROW_DATA_W-1:0] weight_row_o,
  output logic                  weight_row_valid_o,
  output logic [ROW_W-1:0]      weight_row_idx_o,
  output logic                  weight_bank_o,
  output logic                  compute_weights_rdy_o,
  output logic                  done_o,
  output logic                  error_o
);

  wl_state_e         state_q;
  logic [TILE_W-1:0] tiles_q;
  logic [TILE_W-1:0] tile_q;
  logic [TILE_W-1:0] tile_inc;
  logic [ROW_W-1:0]  row_q;
  logic              rd_en_q;
  logic              done_q;
  logic [1:0]        reserved_q, reserved_d;
  logic [1:0]        full_q, full_d;
  logic              rdy_q;
  logic              err_q;
  logic              bank_q;
  logic              issue_row0;
  logic              issue_bank;
  logic              next_ok;
  logic              last_wr;
  logic              unused_inputs;

  // Only the start bit and the tile-count bits of the dimension are used.
  assign unused_inputs = ^{MAC_op_i[2:1], U_dim_i[4:0]};

  assign tile_inc   = tile_q + 3'd1;
  assign issue_row0 = rd_en_q && (row_q == '0);
  assign issue_bank = issue_row0 ? ~bank_q : bank_q;
  // A consume pulse with nothing loaded is a protocol error and is dropped.
  assign next_ok    = next_weight_tile_i && (full_q != 2'd0);

  // Next values of the reserved/loaded bank counters; +1 and -1 together cancel.
  always_comb begin
    reserved_d = reserved_q;
    if (issue_row0 && !next_ok)      reserved_d = reserved_q + 2'd1;
    else if (!issue_row0 && next_ok) reserved_d = reserved_q - 2'd1;
    full_d = full_q;
    if (last_wr && !next_ok)         full_d = full_q + 2'd1;
    else if (!last_wr && next_ok)    full_d = full_q - 2'd1;
  end

  // Bank bookkeeping, ready flag, issue-bank toggle and sticky error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reserved_q <= 2'd0;
      full_q     <= 2'd0;
      rdy_q      <= 1'b0;
      bank_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      full_q     <= full_d;
      rdy_q      <= (full_d != 2'd0);
      bank_q     <= issue_bank;
      if (next_weight_tile_i && (full_q == 2'd0)) err_q <= 1'b1;
    end
  end

  // Load sequencer: issues one row per cycle, parks when both banks are owned.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      tiles_q <= '0;
      tile_q  <= '0;
      row_q   <= '0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (MAC_op_i[0]) begin
            tiles_q <= U_dim_i[7:5];
            tile_q  <= '0;
            row_q   <= '0;
            if (U_dim_i[7:5] == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          row_q <= row_q + 5'd1;
          if (row_q == ROW_LAST) begin
            tile_q <= tile_inc;
            if (tile_inc == tiles_q) begin
              state_q <= ST_DRAIN;
              rd_en_q <= 1'b0;
            end else if (reserved_d == 2'd2) begin
              state_q <= ST_WAIT_BANK;
              rd_en_q <= 1'b0;
            end
          end
        end
        ST_WAIT_BANK: begin
          if (reserved_d < 2'd2) begin
            state_q <= ST_FETCH;
            rd_en_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_wr) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  weight_load_control_unit_row_pipe u_row_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_en_i   (rd_en_q),
    .idx_i     (row_q),
    .bank_i    (issue_bank),
    .rd_data_i (weight_rd_data_i),
    .row_o     (weight_row_o),
    .valid_o   (weight_row_valid_o),
    .idx_o     (weight_row_idx_o),
    .bank_o    (weight_bank_o),
    .last_wr_o (last_wr)
  );

  assign weight_rd_en_o        = rd_en_q;
  assign weight_rd_addr_o      = {tile_q, row_q};
  assign compute_weights_rdy_o = rdy_q;
  assign done_o                = done_q;
  assign error_o               = err_q;

endmodule
